// File: rtl/data_wb_pkg.sv
// Shared CPU types and constants for the write-back stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package data_wb_pkg;

    // Zero register: reads as zero, writes are discarded
    localparam logic [4:0] XZR      = 5'd31;
    // Link register written by BL
    localparam logic [4:0] LINK_REG = 5'd30;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        bl;
        logic [4:0]  rd;
        logic [63:0] alu_result;
        logic [63:0] read_data;
        logic [63:0] pc;
    } memwb_t;

endpackage

// File: rtl/mux2_64.sv
// 64-bit 2:1 multiplexer.
// Latency: combinational.
// Backpressure: none.
module mux2_64 (
    input  logic        sel,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);

    // sel=0 passes a, sel=1 passes b
    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/wb_bypass.sv
// Forwards the in-flight register-file write onto one decode read port.
// Latency: combinational.
// Backpressure: none; follows write-back state directly.
module wb_bypass
    import data_wb_pkg::*;
(
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [63:0] wr_dat,
    input  logic [4:0]  rd_addr,
    input  logic [63:0] rd_raw,
    output logic [63:0] rd_dat
);

    logic hit;

    // XZR reads never forward, so the zero register stays zero at decode
    always_comb begin
        hit    = wr_en && (rd_addr == wr_addr) && (rd_addr != XZR);
        rd_dat = hit ? wr_dat : rd_raw;
    end

endmodule

// File: rtl/data_wb.sv
// LEGv8 write-back stage: MEM/WB register, write-data select, decode bypass, retire counter.
// Latency: mem_* captured on edge N drive the write port until edge N+1; bypass is combinational.
// Backpressure: stall holds the MEM/WB register; flush invalidates it and wins over stall.
module data_wb
    import data_wb_pkg::*;
#(
    parameter int PC_STEP = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_RegWrite,
    input  logic             mem_MemtoReg,
    input  logic             mem_BLsignal,
    input  logic [4:0]       mem_Rd,
    input  logic [63:0]      mem_alu_result,
    input  logic [63:0]      mem_read_data,
    input  logic [63:0]      mem_pc,
    input  logic [4:0]       id_Ra,
    input  logic [4:0]       id_Rb,
    input  logic [63:0]      id_Da_raw,
    input  logic [63:0]      id_Db_raw,
    output logic             RegWrite_wb,
    output logic [4:0]       Rd_wb,
    output logic [63:0]      Dw,
    output logic [63:0]      id_Da,
    output logic [63:0]      id_Db,
    output logic [CNT_W-1:0] retired
);

    memwb_t      wb_q;
    logic [63:0] link_dat;
    logic [63:0] mem_or_alu;
    logic        load_en;

    assign load_en = !flush && !stall;

    // MEM/WB register: flush drops the instruction, stall holds it, otherwise load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_q <= '0;
        end else if (flush) begin
            wb_q.valid     <= 1'b0;
            wb_q.reg_write <= 1'b0;
        end else if (!stall) begin
            wb_q.valid      <= mem_valid;
            wb_q.reg_write  <= mem_RegWrite;
            wb_q.mem_to_reg <= mem_MemtoReg;
            wb_q.bl         <= mem_BLsignal;
            wb_q.rd         <= mem_Rd;
            wb_q.alu_result <= mem_alu_result;
            wb_q.read_data  <= mem_read_data;
            wb_q.pc         <= mem_pc;
        end
    end

    // Count each real instruction once, on the edge it enters write-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (load_en && mem_valid) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Link value wraps at 64 bits
    always_comb begin
        link_dat = wb_q.pc + 64'(PC_STEP);
    end

    mux2_64 u_mux_mem (
        .sel (wb_q.mem_to_reg),
        .a   (wb_q.alu_result),
        .b   (wb_q.read_data),
        .y   (mem_or_alu)
    );

    // BL overrides the load/ALU choice
    mux2_64 u_mux_bl (
        .sel (wb_q.bl),
        .a   (mem_or_alu),
        .b   (link_dat),
        .y   (Dw)
    );

    // Write port address and enable; X31 writes are suppressed
    always_comb begin
        Rd_wb       = wb_q.bl ? LINK_REG : wb_q.rd;
        RegWrite_wb = wb_q.valid && (wb_q.reg_write || wb_q.bl) && (Rd_wb != XZR);
    end

    wb_bypass u_byp_a (
        .wr_en   (RegWrite_wb),
        .wr_addr (Rd_wb),
        .wr_dat  (Dw),
        .rd_addr (id_Ra),
        .rd_raw  (id_Da_raw),
        .rd_dat  (id_Da)
    );

    wb_bypass u_byp_b (
        .wr_en   (RegWrite_wb),
        .wr_addr (Rd_wb),
        .wr_dat  (Dw),
        .rd_addr (id_Rb),
        .rd_raw  (id_Db_raw),
        .rd_dat  (id_Db)
    );

endmodule

// File: doc/data_wb.md
# data_wb

Write-back stage of the pipelined LEGv8 CPU: the writer side of the register file that the decode stage reads. It holds the MEM/WB pipeline register and selects the write-back value: ALU result, load data, or link address for BL. It drives the register-file write port. It also bypasses same-cycle writes onto the decode-stage read data, so decode never sees stale operands. A retired-instruction counter supports bring-up and performance checks.

## Interface
Parameters:
- PC_STEP, 4, byte increment added to the captured PC to form the BL link value.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  invalidate the MEM/WB register; takes priority over stall.
- mem_valid  in  1  MEM stage carries a real instruction.
- mem_RegWrite, mem_MemtoReg, mem_BLsignal  in  1 each  control bits from the MEM stage.
- mem_Rd  in  5  destination register.
- mem_alu_result, mem_read_data, mem_pc  in  64 each  ALU result, load data, and instruction PC.
- id_Ra, id_Rb  in  5 each  decode-stage read addresses (Rn and the Reg2Loc-selected Ab).
- id_Da_raw, id_Db_raw  in  64 each  register-file read data.
- RegWrite_wb  out  1  register-file write enable.
- Rd_wb  out  5  register-file write address.
- Dw  out  64  register-file write data.
- id_Da, id_Db  out  64 each  bypass-corrected read data for decode.
- retired  out  CNT_W  count of instructions captured into write-back.

## Operation
- MEM/WB register fields: valid, RegWrite, MemtoReg, BLsignal, Rd, alu_result, read_data, pc.
- Update rule on each rising clk edge:
  - flush=1: clear valid and RegWrite; other fields are don't-care.
  - else stall=1: hold every field.
  - else: load all fields from the mem_* inputs.
- Write data selection, in priority order:
  - BLsignal=1: Dw = pc + PC_STEP, truncated to 64 bits, wrap-around allowed.
  - else MemtoReg=1: Dw = read_data.
  - else: Dw = alu_result.
- Write address: Rd_wb = 30 when BLsignal=1, otherwise the registered Rd.
- Write enable: RegWrite_wb = valid & (RegWrite | BLsignal) & (Rd_wb != 31). Writes to X31 are suppressed, so XZR stays zero.
- Bypass, evaluated independently for each port:
  - id_Da = Dw when RegWrite_wb=1 and id_Ra == Rd_wb; otherwise id_Da_raw.
  - id_Db follows the same rule using id_Rb and id_Db_raw.
  - id_Ra or id_Rb equal to 31 never bypasses.
- Retired counter:
  - Increments by 1 on every edge where the register loads with mem_valid=1, i.e. stall=0, flush=0.
  - A stalled instruction is counted once.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset (reset=0, asynchronous): all register fields clear to 0 and retired = 0. Resulting outputs: RegWrite_wb=0, Rd_wb=0, Dw=0, id_Da=id_Da_raw, id_Db=id_Db_raw.
- Release of reset is synchronous to clk. Reset asserted mid-stall or mid-flush overrides both.
- Latency: mem_* inputs sampled on edge N drive RegWrite_wb, Rd_wb and Dw from edge N through edge N+1.
- The register file captures the write on edge N+1.
- Bypass outputs are combinational from the registered state and the id_* inputs; the path contains no extra register.
- flush and stall asserted together: the flush result applies.
- Stall held for K cycles: the write-back outputs stay constant across all K cycles. The register file rewrites the same value each cycle, which is harmless.

## Structure
- The shared CPU package holds:
  - the MEM/WB register struct (fields above);
  - the constants XZR = 5'd31 and LINK_REG = 5'd30.
- Reuse the existing 64-bit 2:1 mux for the MemtoReg and BL selections.
- One sub-module: wb_bypass, the comparator and mux pair for one read port, instantiated twice.

## Test plan
- Reset, then load mem_valid=1, RegWrite=1, MemtoReg=0, Rd=5, alu_result=0x1234. One edge later: RegWrite_wb=1, Rd_wb=5, Dw=0x1234, retired=1.
- Load instruction: MemtoReg=1, read_data=0xDEADBEEF, Rd=9 → Dw=0xDEADBEEF. With id_Rb=9 and id_Db_raw=0: id_Db=0xDEADBEEF and id_Da=id_Da_raw.
- BL with pc=0x100 and Rd=0 → Rd_wb=30, Dw=0x104, RegWrite_wb=1. pc=0xFFFF_FFFF_FFFF_FFFC → Dw=0.
- Write to Rd=31 with RegWrite=1 → RegWrite_wb=0. id_Ra=31 returns id_Da_raw unchanged.
- Stall for 3 cycles with new mem_* inputs → outputs unchanged and retired unchanged. Asserting flush and stall together → RegWrite_wb=0 next cycle.
- Drive reset low mid-operation between edges → all outputs clear immediately without waiting for a clock edge, and retired=0.
